wait_state_mem_slave: RTL and testbench

- Parametrised, synthesizable single-port memory slave for the instruction and data ports of MainCPU.
- Successor to the fixed-latency test memory: width, depth and wait states are configurable; adds out-of-range error signalling and a memory-mapped console FIFO with backpressure.
- Two instances sit in the SoC: one on the IP bus, one on the DP bus. The IP instance has its console disabled.

---
 rtl/wait_state_mem_slave.sv | 201 ++++++++++++++++++++
 tb/tb_wait_state_mem_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_mem_slave.sv
// Single-port memory slave with configurable wait states, out-of-range error
// reporting and a memory-mapped console byte FIFO with backpressure.
module wait_state_mem_slave #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter bit          CONSOLE_EN   = 1'b1,
    parameter int unsigned CONSOLE_ADDR = 1023,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                        Clk,
    input  logic                        RST,
    input  logic                        Trans,
    input  logic [ADDR_W-1:0]           AdressBus,
    input  logic                        ReadWrite,
    input  logic [DATA_W-1:0]           MasterWriteBus,
    output logic [DATA_W-1:0]           MasterReadBus,
    output logic                        Ready,
    output logic                        Err,
    output logic [7:0]                  ConData,
    output logic                        ConValid,
    input  logic                        ConReady,
    output logic [$clog2(FIFO_DEPTH):0] ConCount
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = 4;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CON_ADDR = ADDR_W'(CONSOLE_ADDR);
    localparam logic [CNT_W-1:0]  FIFO_MAX = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [7:0]          fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic [ADDR_W-1:0]   cur_addr;
    logic                cur_write;
    logic [7:0]          cur_byte;
    logic                cur_oor;
    logic                cur_console;
    logic                fifo_full;
    logic                pop;
    logic                finish;
    logic                blocked;
    logic                issue;
    logic                push;
    logic [DATA_W-1:0]   rd_data;

    // Transfer attributes: live bus inputs while idle (zero-wait accept), latched otherwise.
    always_comb begin
        cur_addr  = addr_q;
        cur_write = write_q;
        cur_byte  = wdata_q[7:0];
        if (state == S_IDLE) begin
            cur_addr  = AdressBus;
            cur_write = ReadWrite;
            cur_byte  = MasterWriteBus[7:0];
        end
    end

    assign cur_oor     = {1'b0, cur_addr} >= DEPTH_X;
    assign cur_console = CONSOLE_EN && (cur_addr == CON_ADDR);
    assign fifo_full   = (count == FIFO_MAX);
    assign pop         = ConValid && ConReady;

    // A transfer is ready to complete; a console write into a full FIFO must wait for a pop.
    assign finish  = ((state == S_IDLE) && Trans && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (wait_cnt == WAIT_W'(1))) ||
                     (state == S_HOLD);
    assign blocked = cur_console && cur_write && fifo_full && !pop;
    assign issue   = finish && !blocked;
    assign push    = issue && cur_console && cur_write;

    // Read data source for the response cycle.
    always_comb begin
        rd_data = '0;
        if (cur_console) begin
            rd_data = DATA_W'(count);
        end else if (!cur_oor) begin
            rd_data = mem[cur_addr[IDX_W-1:0]];
        end
    end

    // Transfer FSM with registered Ready/Err/read-data outputs.
    always_ff @(posedge Clk) begin
        if (RST) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            Ready         <= 1'b0;
            Err           <= 1'b0;
            MasterReadBus <= '0;
        end else begin
            Ready         <= 1'b0;
            Err           <= 1'b0;
            MasterReadBus <= '0;
            case (state)
                S_IDLE: begin
                    if (Trans) begin
                        addr_q   <= AdressBus;
                        write_q  <= ReadWrite;
                        wdata_q  <= MasterWriteBus;
                        wait_cnt <= WAIT_W'(WAIT_CYCLES);
                        if (WAIT_CYCLES != 0) begin
                            state <= S_WAIT;
                        end else if (blocked) begin
                            state <= S_HOLD;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= blocked ? S_HOLD : S_RESP;
                    end
                end
                S_HOLD: begin
                    if (!blocked) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (issue) begin
                Ready         <= 1'b1;
                Err           <= cur_oor;
                MasterReadBus <= cur_write ? '0 : rd_data;
            end
        end
    end

    // Memory write commits at the edge closing the response cycle; contents are never reset.
    always_ff @(posedge Clk) begin
        if (!RST && (state == S_RESP) && cur_write && !cur_oor && !cur_console) begin
            mem[cur_addr[IDX_W-1:0]] <= wdata_q;
        end
    end

    // Console FIFO storage (data only, not reset).
    always_ff @(posedge Clk) begin
        if (!RST && push) begin
            fifo[wr_ptr] <= cur_byte;
        end
    end

    // Console FIFO pointers and occupancy; reset discards all entries.
    always_ff @(posedge Clk) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign ConData  = fifo[rd_ptr];
    assign ConValid = (count != '0);
    assign ConCount = count;

endmodule

// File: tb/tb_wait_state_mem_slave.sv
// Directed bench: zero-wait instance without console, three-wait instance with console.
module tb_wait_state_mem_slave;

    logic        clk = 1'b0;
    logic        rst;

    logic        trans0, rw0, ready0, err0, con_valid0, con_ready0;
    logic [15:0] addr0, wdata0, rdata0;
    logic [7:0]  con_data0;
    logic [3:0]  con_count0;

    logic        trans1, rw1, ready1, err1, con_valid1, con_ready1;
    logic [15:0] addr1, wdata1, rdata1;
    logic [7:0]  con_data1;
    logic [3:0]  con_count1;

    int passed = 0;
    int total  = 0;

    byte got[$];
    string msg = "hello world";

    always #5 clk = ~clk;

    wait_state_mem_slave #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0),
        .CONSOLE_EN(1'b0), .CONSOLE_ADDR(1023), .FIFO_DEPTH(8)
    ) dut0 (
        .Clk(clk), .RST(rst), .Trans(trans0), .AdressBus(addr0), .ReadWrite(rw0),
        .MasterWriteBus(wdata0), .MasterReadBus(rdata0), .Ready(ready0), .Err(err0),
        .ConData(con_data0), .ConValid(con_valid0), .ConReady(con_ready0), .ConCount(con_count0)
    );

    wait_state_mem_slave #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(3),
        .CONSOLE_EN(1'b1), .CONSOLE_ADDR(1023), .FIFO_DEPTH(8)
    ) dut1 (
        .Clk(clk), .RST(rst), .Trans(trans1), .AdressBus(addr1), .ReadWrite(rw1),
        .MasterWriteBus(wdata1), .MasterReadBus(rdata1), .Ready(ready1), .Err(err1),
        .ConData(con_data1), .ConValid(con_valid1), .ConReady(con_ready1), .ConCount(con_count1)
    );

    // Console sink: record every byte popped from dut1.
    always @(posedge clk) begin
        if (con_valid1 && con_ready1) got.push_back(con_data1);
    end

    // One transfer on dut0; lat counts cycles from accept to Ready (0 = timeout).
    task automatic xfer0(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd, output logic er, output int lat, output logic clean);
        clean = 1'b1; lat = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        trans0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = wd;
        @(posedge clk);
        @(negedge clk);
        trans0 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (ready0) begin lat = i; rd = rdata0; er = err0; break; end
            if (err0 || rdata0 !== 16'h0) clean = 1'b0;
            @(negedge clk);
        end
        if (lat != 0) begin
            @(negedge clk);
            if (ready0 || err0 || rdata0 !== 16'h0) clean = 1'b0;
        end
    endtask

    // One transfer on dut1; same conventions as xfer0.
    task automatic xfer1(input logic rw, input logic [15:0] a, input logic [15:0] wd,
                         output logic [15:0] rd, output logic er, output int lat, output logic clean);
        clean = 1'b1; lat = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        trans1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = wd;
        @(posedge clk);
        @(negedge clk);
        trans1 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (ready1) begin lat = i; rd = rdata1; er = err1; break; end
            if (err1 || rdata1 !== 16'h0) clean = 1'b0;
            @(negedge clk);
        end
        if (lat != 0) begin
            @(negedge clk);
            if (ready1 || err1 || rdata1 !== 16'h0) clean = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trans0 = 0; rw0 = 0; addr0 = 0; wdata0 = 0; con_ready0 = 0;
        trans1 = 0; rw1 = 0; addr1 = 0; wdata1 = 0; con_ready1 = 0;
        repeat (3) @(negedge clk);
        total++; if ({ready0, err0, rdata0} !== 17'h0) $display("FAIL reset_dut0: got %h required 0", {ready0, err0, rdata0}); else passed++;
        total++; if ({ready1, err1} !== 2'b00) $display("FAIL reset_ready_err: got %b required 00", {ready1, err1}); else passed++;
        total++; if (rdata1 !== 16'h0) $display("FAIL reset_rdata: got %h required 0000", rdata1); else passed++;
        total++; if (con_valid1 !== 1'b0) $display("FAIL reset_convalid: got %b required 0", con_valid1); else passed++;
        total++; if (con_count1 !== 4'd0) $display("FAIL reset_concount: got %0d required 0", con_count1); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [15:0] rd; logic er, cl; int lat;
        xfer0(1'b1, 16'd5, 16'h1234, rd, er, lat, cl);
        total++; if (lat !== 1 || er !== 1'b0) $display("FAIL zw_write: lat %0d err %b required lat 1 err 0", lat, er); else passed++;
        xfer0(1'b0, 16'd5, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'h1234) $display("FAIL zw_read_data: got %h required 1234", rd); else passed++;
        total++; if (lat !== 1 || er !== 1'b0 || cl !== 1'b1) $display("FAIL zw_read_timing: lat %0d err %b clean %b required 1 0 1", lat, er, cl); else passed++;
        xfer0(1'b1, 16'd1023, 16'h5A5A, rd, er, lat, cl);
        xfer0(1'b0, 16'd1023, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'h5A5A || er !== 1'b0) $display("FAIL nocon_plain_mem: got %h err %b required 5a5a err 0", rd, er); else passed++;
        total++; if (con_valid0 !== 1'b0 || con_count0 !== 4'd0) $display("FAIL nocon_fifo_idle: valid %b count %0d required 0 0", con_valid0, con_count0); else passed++;
        xfer0(1'b0, 16'd1024, 16'h0, rd, er, lat, cl);
        total++; if (er !== 1'b1 || rd !== 16'h0 || lat !== 1) $display("FAIL zw_first_oor: err %b data %h lat %0d required 1 0000 1", er, rd, lat); else passed++;
    endtask

    task automatic test_wait_states();
        logic [15:0] rd; logic er, cl; int lat;
        xfer1(1'b1, 16'd0, 16'd104, rd, er, lat, cl);
        total++; if (lat !== 4 || er !== 1'b0) $display("FAIL ws_write: lat %0d err %b required lat 4 err 0", lat, er); else passed++;
        xfer1(1'b0, 16'd0, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'd104) $display("FAIL ws_read_data: got %0d required 104", rd); else passed++;
        total++; if (lat !== 4 || cl !== 1'b1) $display("FAIL ws_read_timing: lat %0d clean %b required 4 1", lat, cl); else passed++;
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd; logic er, cl; int lat;
        xfer1(1'b1, 16'd476, 16'h0476, rd, er, lat, cl);
        xfer1(1'b1, 16'd1500, 16'hBEEF, rd, er, lat, cl);
        total++; if (er !== 1'b1 || lat !== 4 || cl !== 1'b1) $display("FAIL oor_write: err %b lat %0d clean %b required 1 4 1", er, lat, cl); else passed++;
        xfer1(1'b0, 16'd1500, 16'h0, rd, er, lat, cl);
        total++; if (er !== 1'b1 || rd !== 16'h0 || cl !== 1'b1) $display("FAIL oor_read: err %b data %h clean %b required 1 0000 1", er, rd, cl); else passed++;
        xfer1(1'b0, 16'd476, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'h0476 || er !== 1'b0) $display("FAIL oor_alias_untouched: got %h err %b required 0476 0", rd, er); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd; logic er, cl; int lat;
        int n, last;
        for (int i = 0; i < 4; i++) xfer1(1'b1, 16'(10 + i), 16'(16'h1000 + 16'h11 * i), rd, er, lat, cl);
        @(negedge clk);
        trans1 = 1'b1; rw1 = 1'b0; addr1 = 16'd10;
        n = 0; last = 0;
        for (int c = 1; c <= 60 && n < 4; c++) begin
            @(negedge clk);
            if (ready1) begin
                total++; if (rdata1 !== 16'(16'h1000 + 16'h11 * n)) $display("FAIL b2b_data%0d: got %h required %h", n, rdata1, 16'(16'h1000 + 16'h11 * n)); else passed++;
                total++; if ((n == 0 && c != 4) || (n > 0 && c - last != 5)) $display("FAIL b2b_spacing%0d: ready at cycle %0d previous %0d required gap 5", n, c, last); else passed++;
                last = c; n++;
                addr1 = 16'(10 + n);
                if (n == 4) trans1 = 1'b0;
            end
        end
        trans1 = 1'b0;
        total++; if (n !== 4) $display("FAIL b2b_count: got %0d responses required 4", n); else passed++;
    endtask

    task automatic test_console();
        logic [15:0] rd; logic er, cl; int lat;
        logic ok, stalled;
        got.delete();
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            xfer1(1'b1, 16'd1023, {8'hA5, msg[i]}, rd, er, lat, cl);
            if (lat != 4 || er !== 1'b0) ok = 1'b0;
        end
        total++; if (ok !== 1'b1) $display("FAIL con_fill: some of first 8 writes late or erred, ok %b required 1", ok); else passed++;
        total++; if (con_count1 !== 4'd8 || con_data1 !== 8'h68) $display("FAIL con_full_state: count %0d head %h required 8 68", con_count1, con_data1); else passed++;
        @(negedge clk);
        trans1 = 1'b1; rw1 = 1'b1; addr1 = 16'd1023; wdata1 = {8'hFF, msg[8]};
        @(posedge clk);
        @(negedge clk);
        trans1 = 1'b0;
        stalled = 1'b1;
        repeat (10) begin
            if (ready1) stalled = 1'b0;
            @(negedge clk);
        end
        total++; if (stalled !== 1'b1 || con_count1 !== 4'd8) $display("FAIL con_stall: stalled %b count %0d required 1 8", stalled, con_count1); else passed++;
        con_ready1 = 1'b1;
        @(negedge clk);
        con_ready1 = 1'b0;
        total++; if (ready1 !== 1'b1 || err1 !== 1'b0 || con_count1 !== 4'd8) $display("FAIL con_release: ready %b err %b count %0d required 1 0 8", ready1, err1, con_count1); else passed++;
        xfer1(1'b0, 16'd1023, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'd8 || er !== 1'b0) $display("FAIL con_read8: got %0d err %b required 8 0", rd, er); else passed++;
        @(negedge clk);
        con_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        con_ready1 = 1'b0;
        xfer1(1'b0, 16'd1023, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'd5) $display("FAIL con_read5: got %0d required 5", rd); else passed++;
        xfer1(1'b1, 16'd1023, {8'h00, msg[9]}, rd, er, lat, cl);
        xfer1(1'b1, 16'd1023, {8'h3C, msg[10]}, rd, er, lat, cl);
        total++; if (con_count1 !== 4'd7) $display("FAIL con_count7: got %0d required 7", con_count1); else passed++;
        con_ready1 = 1'b1;
        for (int i = 0; i < 30 && con_valid1; i++) @(negedge clk);
        con_ready1 = 1'b0;
        ok = (got.size() == 11);
        for (int i = 0; i < 11 && ok; i++) if (got[i] !== msg[i]) ok = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL con_order: %0d bytes drained, sequence wrong or short, required 11 in order", got.size()); else passed++;
        xfer1(1'b0, 16'd1023, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'd0 || con_valid1 !== 1'b0) $display("FAIL con_empty: count read %0d valid %b required 0 0", rd, con_valid1); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; logic er, cl; int lat;
        logic seen;
        xfer1(1'b1, 16'd7, 16'h0000, rd, er, lat, cl);
        xfer1(1'b1, 16'd1023, 16'h005A, rd, er, lat, cl);
        total++; if (con_valid1 !== 1'b1) $display("FAIL rmid_pre_valid: got %b required 1", con_valid1); else passed++;
        @(negedge clk);
        trans1 = 1'b1; rw1 = 1'b1; addr1 = 16'd7; wdata1 = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        trans1 = 1'b0; rst = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready1) seen = 1'b1;
        end
        rst = 1'b0;
        total++; if (seen !== 1'b0) $display("FAIL rmid_no_ready: ready seen %b required 0", seen); else passed++;
        total++; if (con_valid1 !== 1'b0 || con_count1 !== 4'd0) $display("FAIL rmid_fifo_flushed: valid %b count %0d required 0 0", con_valid1, con_count1); else passed++;
        xfer1(1'b0, 16'd7, 16'h0, rd, er, lat, cl);
        total++; if (rd !== 16'h0000 || lat !== 4 || er !== 1'b0) $display("FAIL rmid_mem_kept: data %h lat %0d err %b required 0000 4 0", rd, lat, er); else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_out_of_range();
        test_back_to_back();
        test_console();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
